pawn: RTL and testbench

- Hardware pawn move generator used as an accelerator for the chess engine.
- The CPU programs a source board address, a destination buffer address and a square (x,y) through an Avalon-MM slave.
- The block reads the 64-byte board over an Avalon-MM master, generates every legal pawn move from that square, and writes one complete 64-byte result board per move into the destination buffer.

---
 rtl/chess_pkg.sv | 39 +++
 rtl/pawn_if.sv | 30 +++
 rtl/pawn_target_calc.sv | 40 ++++
 rtl/pawn.sv | 145 ++++++++++++++
 tb/tb_pawn.sv | 207 ++++++++++++++++++++
 5 files changed

// File: rtl/chess_pkg.sv
// rtl/chess_pkg.sv - piece codes, register map and pawn helpers for the pawn move generator
package chess_pkg;
    localparam int BOARD_SQUARES = 64;
    localparam int MAX_MOVES     = 4;

    typedef logic signed [7:0] piece_t;

    // White codes are positive, black codes are their negation.
    localparam piece_t EMPTY   = 8'sd0;
    localparam piece_t W_PAWN0 = 8'sd1,  W_PAWN1 = 8'sd2,  W_PAWN2 = 8'sd3,  W_PAWN3 = 8'sd4;
    localparam piece_t W_PAWN4 = 8'sd5,  W_PAWN5 = 8'sd6,  W_PAWN6 = 8'sd7,  W_PAWN7 = 8'sd8;
    localparam piece_t B_PAWN0 = -8'sd1, B_PAWN1 = -8'sd2, B_PAWN2 = -8'sd3, B_PAWN3 = -8'sd4;
    localparam piece_t B_PAWN4 = -8'sd5, B_PAWN5 = -8'sd6, B_PAWN6 = -8'sd7, B_PAWN7 = -8'sd8;
    localparam piece_t ROOK    = 8'sd9,  KNIGHT  = 8'sd10, BISHOP  = 8'sd11, KING    = 8'sd12;
    localparam piece_t QUEEN0  = 8'sd39, QUEEN1  = 8'sd40, QUEEN2  = 8'sd41, QUEEN3  = 8'sd42;
    localparam piece_t QUEEN4  = 8'sd43, QUEEN5  = 8'sd44, QUEEN6  = 8'sd45, QUEEN7  = 8'sd46;
    localparam piece_t QUEEN8  = 8'sd47;
    localparam piece_t PROMO_OFFSET = 8'sd39;

    localparam logic [3:0] REG_CTRL = 4'd0;
    localparam logic [3:0] REG_SRC  = 4'd1;
    localparam logic [3:0] REG_DST  = 4'd2;
    localparam logic [3:0] REG_X    = 4'd3;
    localparam logic [3:0] REG_Y    = 4'd4;

    typedef enum logic [2:0] {S_IDLE, S_LOAD, S_GEN, S_WRITE, S_DONE} state_e;

    function automatic logic is_pawn(input piece_t p);
        return (p >= 8'sd1 && p <= 8'sd8) || (p <= -8'sd1 && p >= -8'sd8);
    endfunction

    function automatic piece_t promote(input piece_t p);
        return p[7] ? p - PROMO_OFFSET : p + PROMO_OFFSET;
    endfunction

    function automatic logic opposite(input piece_t p, input piece_t t);
        return (t != EMPTY) && (t[7] != p[7]);
    endfunction
endpackage

// File: rtl/pawn_if.sv
// rtl/pawn_if.sv - register slave and byte-wide memory master bus of the pawn move generator
interface pawn_if;
    logic        slave_waitrequest;
    logic [3:0]  slave_address;
    logic        slave_read;
    logic [31:0] slave_readdata;
    logic        slave_write;
    logic [31:0] slave_writedata;
    logic        master_waitrequest;
    logic [31:0] master_address;
    logic        master_read;
    logic [31:0] master_readdata;
    logic        master_readdatavalid;
    logic        master_write;
    logic [31:0] master_writedata;

    // slave: the accelerator side; master: the host/memory side driving it
    modport slave (
        output slave_waitrequest, slave_readdata,
        output master_address, master_read, master_write, master_writedata,
        input  slave_address, slave_read, slave_write, slave_writedata,
        input  master_waitrequest, master_readdata, master_readdatavalid
    );
    modport master (
        input  slave_waitrequest, slave_readdata,
        input  master_address, master_read, master_write, master_writedata,
        output slave_address, slave_read, slave_write, slave_writedata,
        output master_waitrequest, master_readdata, master_readdatavalid
    );
endinterface

// File: rtl/pawn_target_calc.sv
// rtl/pawn_target_calc.sv - combinational pawn move targets in emission order
module pawn_target_calc
    import chess_pkg::*;
(
    input  logic [7:0]                 board_i [BOARD_SQUARES],
    input  logic [2:0]                 x_i,
    input  logic [2:0]                 y_i,
    input  piece_t                     code_i,
    output logic [MAX_MOVES-1:0]       valid_o,
    output logic [MAX_MOVES-1:0][5:0]  to_o,
    output logic [MAX_MOVES-1:0][7:0]  placed_o
);
    logic       pawn, white, fwd_ok, dbl_ok, promo;
    logic [2:0] y1, y2;
    logic [5:0] sq1, sq2, sql, sqr;
    piece_t     fwd_code;

    always_comb begin
        pawn     = is_pawn(code_i);
        white    = ~code_i[7];
        y1       = white ? y_i + 3'd1 : y_i - 3'd1;
        y2       = white ? y_i + 3'd2 : y_i - 3'd2;
        // A pawn on its last rank has no forward square; y would wrap otherwise.
        fwd_ok   = pawn && (white ? (y_i != 3'd7) : (y_i != 3'd0));
        dbl_ok   = pawn && (white ? (y_i == 3'd1) : (y_i == 3'd6));
        promo    = white ? (y1 == 3'd7) : (y1 == 3'd0);
        fwd_code = promo ? promote(code_i) : code_i;
        sq1      = {y1, x_i};
        sq2      = {y2, x_i};
        sql      = {y1, x_i - 3'd1};
        sqr      = {y1, x_i + 3'd1};

        valid_o[0] = fwd_ok && (board_i[sq1] == 8'd0);
        valid_o[1] = dbl_ok && (board_i[sq1] == 8'd0) && (board_i[sq2] == 8'd0);
        valid_o[2] = fwd_ok && (x_i != 3'd0) && opposite(code_i, board_i[sql]);
        valid_o[3] = fwd_ok && (x_i != 3'd7) && opposite(code_i, board_i[sqr]);
        to_o       = {sqr, sql, sq2, sq1};
        placed_o   = {fwd_code, fwd_code, code_i, fwd_code};
    end
endmodule

// File: rtl/pawn.sv
// rtl/pawn.sv - pawn move generator: loads a board, writes one result board per legal move
module pawn
    import chess_pkg::*;
(
    input logic   clk,
    input logic   rst,
    pawn_if.slave bus
);
    state_e      state_q, state_d;
    logic [31:0] src_q, dst_q, run_src_q, run_dst_q;
    logic [2:0]  x_q, y_q, run_x_q, run_y_q;
    logic [5:0]  idx_q, idx_d;
    logic        rd_pend_q, rd_pend_d;
    logic [2:0]  mv_q, mv_d, cnt_q, cnt_d;
    logic [7:0]  board_q [BOARD_SQUARES];

    logic [MAX_MOVES-1:0]      mv_valid;
    logic [MAX_MOVES-1:0][5:0] mv_to;
    logic [MAX_MOVES-1:0][7:0] mv_code;
    logic [5:0]                from_sq, to_sq;
    logic [7:0]                out_byte;
    logic                      start;

    assign from_sq = {run_y_q, run_x_q};
    assign to_sq   = mv_to[mv_q[1:0]];
    assign start   = bus.slave_write && (bus.slave_address == REG_CTRL);

    pawn_target_calc u_calc (
        .board_i  (board_q),
        .x_i      (run_x_q),
        .y_i      (run_y_q),
        .code_i   (board_q[from_sq]),
        .valid_o  (mv_valid),
        .to_o     (mv_to),
        .placed_o (mv_code)
    );

    always_comb begin
        out_byte = board_q[idx_q];
        if (idx_q == from_sq)    out_byte = 8'd0;
        else if (idx_q == to_sq) out_byte = mv_code[mv_q[1:0]];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            src_q <= '0; dst_q <= '0; x_q <= '0; y_q <= '0;
        end else if (bus.slave_write) begin
            case (bus.slave_address)
                REG_SRC: src_q <= bus.slave_writedata;
                REG_DST: dst_q <= bus.slave_writedata;
                REG_X:   x_q   <= bus.slave_writedata[2:0];
                REG_Y:   y_q   <= bus.slave_writedata[2:0];
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            idx_q     <= '0;
            rd_pend_q <= 1'b0;
            mv_q      <= '0;
            cnt_q     <= '0;
            run_src_q <= '0; run_dst_q <= '0; run_x_q <= '0; run_y_q <= '0;
            for (int i = 0; i < BOARD_SQUARES; i++) board_q[i] <= 8'd0;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            rd_pend_q <= rd_pend_d;
            mv_q      <= mv_d;
            cnt_q     <= cnt_d;
            // Register snapshot at start so writes during a run only affect the next one.
            if (state_q == S_IDLE && start) begin
                run_src_q <= src_q; run_dst_q <= dst_q; run_x_q <= x_q; run_y_q <= y_q;
            end
            if (state_q == S_LOAD && rd_pend_q && bus.master_readdatavalid)
                board_q[idx_q] <= bus.master_readdata[7:0];
        end
    end

    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        rd_pend_d = rd_pend_q;
        mv_d      = mv_q;
        cnt_d     = cnt_q;
        bus.master_read      = 1'b0;
        bus.master_write     = 1'b0;
        bus.master_address   = '0;
        bus.master_writedata = '0;
        case (state_q)
            S_IDLE: if (start) begin
                state_d = S_LOAD; idx_d = '0; rd_pend_d = 1'b0; mv_d = '0; cnt_d = '0;
            end
            S_LOAD: begin
                if (!rd_pend_q) begin
                    bus.master_read    = 1'b1;
                    bus.master_address = run_src_q + {26'd0, idx_q};
                    if (!bus.master_waitrequest) rd_pend_d = 1'b1;
                end else if (bus.master_readdatavalid) begin
                    rd_pend_d = 1'b0;
                    idx_d     = idx_q + 6'd1;
                    if (idx_q == 6'd63) state_d = S_GEN;
                end
            end
            S_GEN: begin
                if (mv_q == 3'(MAX_MOVES))    state_d = S_DONE;
                else if (mv_valid[mv_q[1:0]]) begin state_d = S_WRITE; idx_d = '0; end
                else                          mv_d = mv_q + 3'd1;
            end
            S_WRITE: begin
                bus.master_write     = 1'b1;
                bus.master_address   = run_dst_q + {23'd0, cnt_q, idx_q};
                bus.master_writedata = {24'd0, out_byte};
                if (!bus.master_waitrequest) begin
                    idx_d = idx_q + 6'd1;
                    if (idx_q == 6'd63) begin
                        cnt_d = cnt_q + 3'd1; mv_d = mv_q + 3'd1; state_d = S_GEN;
                    end
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        bus.slave_waitrequest = 1'b0;
        bus.slave_readdata    = '0;
        if (bus.slave_read) begin
            case (bus.slave_address)
                REG_CTRL: begin
                    if (state_q != S_IDLE) bus.slave_waitrequest = 1'b1;
                    else                   bus.slave_readdata = {29'd0, cnt_q};
                end
                REG_SRC: bus.slave_readdata = src_q;
                REG_DST: bus.slave_readdata = dst_q;
                REG_X:   bus.slave_readdata = {29'd0, x_q};
                REG_Y:   bus.slave_readdata = {29'd0, y_q};
                default: bus.slave_readdata = '0;
            endcase
        end
    end
endmodule

// File: tb/tb_pawn.sv
// tb/tb_pawn.sv - directed vector bench for the pawn move generator
module tb_pawn;
    import chess_pkg::*;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    pawn_if bus();
    pawn dut (.clk(clk), .rst(rst), .bus(bus));

    typedef struct packed {
        int             setup;
        int             x;
        int             y;
        int             src;
        int             dst;
        int             n;
        logic [3:0][7:0] to;
        logic [3:0][7:0] code;
    } vec_t;

    int          total = 0;
    int          bad   = 0;
    int          writes = 0;
    logic [7:0]  mem    [1024];
    logic [7:0]  board  [64];
    logic [7:0]  exp_b  [64];
    vec_t        vecs   [7];
    logic        rd_accept;
    logic [31:0] rd_addr;

    // Memory model: random stalls, one-cycle read latency, byte writes.
    initial begin
        bus.master_waitrequest   = 1'b0;
        bus.master_readdata      = '0;
        bus.master_readdatavalid = 1'b0;
        rd_accept = 1'b0;
        rd_addr   = '0;
        forever begin
            @(negedge clk);
            bus.master_readdatavalid = rd_accept;
            bus.master_readdata      = rd_accept ? {24'd0, mem[rd_addr[9:0]]} : 32'd0;
            bus.master_waitrequest   = ($urandom_range(0, 3) == 0);
            rd_accept = bus.master_read && !bus.master_waitrequest;
            rd_addr   = bus.master_address;
            if (bus.master_write && !bus.master_waitrequest) begin
                mem[bus.master_address[9:0]] = bus.master_writedata[7:0];
                writes++;
            end
            if (bus.master_read && bus.master_write) begin
                total++; bad++;
                $display("FAIL rw_overlap: got read=1 write=1 want not both");
            end
        end
    end

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d want %0d", name, act, exp);
        end
    endtask

    task automatic wr(input logic [3:0] a, input logic [31:0] d);
        @(negedge clk);
        bus.slave_address = a; bus.slave_writedata = d; bus.slave_write = 1'b1;
        @(negedge clk);
        bus.slave_write = 1'b0;
    endtask

    task automatic rd(input logic [3:0] a, output logic [31:0] d, output bit ok);
        @(negedge clk);
        bus.slave_address = a; bus.slave_read = 1'b1;
        ok = 1'b0; d = '0;
        for (int i = 0; i < 20000; i++) begin
            #1;
            if (!bus.slave_waitrequest) begin d = bus.slave_readdata; ok = 1'b1; break; end
            @(negedge clk);
        end
        @(negedge clk);
        bus.slave_read = 1'b0;
    endtask

    task automatic build(input int id);
        logic [7:0] back [8];
        back = '{8'd9, 8'd10, 8'd11, 8'd39, 8'd12, 8'd11, 8'd10, 8'd9};
        for (int i = 0; i < 64; i++) board[i] = 8'h00;
        if (id <= 2) begin
            for (int c = 0; c < 8; c++) begin
                board[c]      = back[c];
                board[8 + c]  = 8'(c + 1);
                board[48 + c] = 8'(-(c + 1));
                board[56 + c] = 8'(0) - back[c];
            end
        end
        if (id == 1) board[18] = 8'hF6;
        if (id == 2) begin board[17] = 8'hF6; board[19] = 8'hF5; end
        if (id == 3) board[48] = 8'd3;
        if (id == 4) begin board[13] = 8'hFE; board[6] = 8'd9; end
    endtask

    task automatic load_and_start(input vec_t v);
        build(v.setup);
        for (int i = 0; i < 1024; i++) mem[i] = 8'hEE;
        for (int i = 0; i < 64; i++) mem[v.src + i] = board[i];
        writes = 0;
        wr(REG_SRC, 32'(v.src));
        wr(REG_DST, 32'(v.dst));
        wr(REG_X, 32'(v.x));
        wr(REG_Y, 32'(v.y));
        wr(REG_CTRL, 32'd1);
    endtask

    task automatic run_vec(input vec_t v, input string tag);
        logic [31:0] d;
        bit          ok;
        int          from, badi;
        load_and_start(v);
        wr(REG_X, 32'(7 - v.x));
        wr(REG_CTRL, 32'd1);
        rd(REG_CTRL, d, ok);
        chk({tag, ".done"}, int'(ok), 1);
        chk({tag, ".status"}, int'(d), v.n);
        chk({tag, ".writes"}, writes, 64 * v.n);
        from = v.y * 8 + v.x;
        for (int k = 0; k < v.n; k++) begin
            for (int i = 0; i < 64; i++) exp_b[i] = board[i];
            exp_b[from]    = 8'h00;
            exp_b[v.to[k]] = v.code[k];
            badi = -1;
            for (int i = 0; i < 64; i++)
                if (badi < 0 && mem[v.dst + 64 * k + i] !== exp_b[i]) badi = i;
            total++;
            if (badi >= 0) begin
                bad++;
                $display("FAIL %s.board%0d byte %0d: got %02h want %02h", tag, k, badi,
                         mem[v.dst + 64 * k + badi], exp_b[badi]);
            end
        end
        rd(REG_X, d, ok);
        chk({tag, ".xreg"}, int'(d), 7 - v.x);
    endtask

    function automatic vec_t mk(input int s, x, y, src, dst, n,
                                input int t0, t1, t2, t3, input int c0, c1, c2, c3);
        vec_t v;
        v.setup = s; v.x = x; v.y = y; v.src = src; v.dst = dst; v.n = n;
        v.to   = {8'(t3), 8'(t2), 8'(t1), 8'(t0)};
        v.code = {8'(c3), 8'(c2), 8'(c1), 8'(c0)};
        return v;
    endfunction

    initial begin
        logic [31:0] d;
        bit          ok;
        bus.slave_address = '0; bus.slave_read = 1'b0;
        bus.slave_write = 1'b0; bus.slave_writedata = '0;
        for (int i = 0; i < 1024; i++) mem[i] = 8'h00;

        vecs[0] = mk(0, 2, 1,   0,   0, 2, 18, 26,  0,  0,   3,   3, 0, 0);
        vecs[1] = mk(1, 2, 1,   0, 256, 0,  0,  0,  0,  0,   0,   0, 0, 0);
        vecs[2] = mk(2, 2, 1, 512,   0, 4, 18, 26, 17, 19,   3,   3, 3, 3);
        vecs[3] = mk(0, 4, 6,   0, 128, 2, 44, 36,  0,  0,  -5,  -5, 0, 0);
        vecs[4] = mk(3, 0, 6, 512,   0, 1, 56,  0,  0,  0,  42,   0, 0, 0);
        vecs[5] = mk(4, 5, 1,   0, 256, 2,  5,  6,  0,  0, -41, -41, 0, 0);
        vecs[6] = mk(0, 3, 3,   0, 256, 0,  0,  0,  0,  0,   0,   0, 0, 0);

        rst = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst.master_read", int'(bus.master_read), 0);
        chk("rst.master_write", int'(bus.master_write), 0);
        chk("rst.master_address", int'(bus.master_address), 0);
        rst = 1'b0;
        for (int a = 0; a < 6; a++) begin
            rd(4'(a), d, ok);
            chk($sformatf("rst.reg%0d", a), int'(d), 0);
        end

        for (int v = 0; v < 7; v++) run_vec(vecs[v], $sformatf("vec%0d", v));

        wr(REG_SRC, 32'h1234_5678);
        rd(4'd9, d, ok);
        chk("unmapped.reg9", int'(d), 0);
        rd(REG_SRC, d, ok);
        chk("reg.src", int'(d), 32'h1234_5678);

        load_and_start(vecs[0]);
        repeat (30) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("abort.master_read", int'(bus.master_read), 0);
        chk("abort.master_write", int'(bus.master_write), 0);
        rst = 1'b0;
        rd(REG_CTRL, d, ok);
        chk("abort.idle", int'(ok), 1);
        chk("abort.status", int'(d), 0);
        chk("abort.writes", writes, 0);
        rd(REG_DST, d, ok);
        chk("abort.dst_cleared", int'(d), 0);
        run_vec(vecs[0], "rerun");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
